vec_add_ctrl: RTL and testbench

- Sequencer for the packed 4x16-bit lane adder datapath (64-bit word = four independent 16-bit lanes).
- On `start`, streams `len` 64-bit words from two source memories (A, B).
- Adds each word pair lane-wise and writes the results to a destination memory (Y).
- Sits between the NLP accelerator's command logic and its vector SRAMs; sustains one word per cycle after pipeline fill.

---
 rtl/vec_add_ctrl_if.sv | 42 ++++
 rtl/vec_add_ctrl.sv | 158 +++++++++++++++
 tb/tb_vec_add_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_add_ctrl_if.sv
// Command and memory-port bundle for the 4x16-bit lane adder sequencer.
// The master side is the command issuer together with the vector SRAMs.
// The slave side is the sequencer itself.
interface vec_add_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] y_base;
    logic              busy;
    logic              done;

    logic              a_rd_en;
    logic [ADDR_W-1:0] a_rd_addr;
    logic [63:0]       a_rd_data;
    logic              b_rd_en;
    logic [ADDR_W-1:0] b_rd_addr;
    logic [63:0]       b_rd_data;

    logic              y_wr_en;
    logic [ADDR_W-1:0] y_wr_addr;
    logic [63:0]       y_wr_data;

    modport master (
        output start, len, a_base, b_base, y_base,
        output a_rd_data, b_rd_data,
        input  busy, done,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  y_wr_en, y_wr_addr, y_wr_data
    );

    modport slave (
        input  start, len, a_base, b_base, y_base,
        input  a_rd_data, b_rd_data,
        output busy, done,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output y_wr_en, y_wr_addr, y_wr_data
    );
endinterface

// File: rtl/vec_add_ctrl.sv
// Sequencer for the packed 4x16-bit lane adder.
// A command streams len word pairs from A and B, adds them lane by lane, and
// writes the sums to Y. Reads issue one per cycle. Each write lands two cycles
// after its read, so after the pipeline fills the block moves one word per cycle.
module vec_add_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    vec_add_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;

    // Command fields captured when a start is accepted
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] a_base_q;
    logic [ADDR_W-1:0] b_base_q;
    logic [ADDR_W-1:0] y_base_q;

    // Read-side sequencing
    logic [LEN_W-1:0]  rd_idx;
    logic [LEN_W-1:0]  rd_idx_nxt;
    logic              last_rd;
    logic              rd_en_q;
    logic [ADDR_W-1:0] a_addr_q;
    logic [ADDR_W-1:0] b_addr_q;

    // Status outputs
    logic              busy_q;
    logic              done_q;

    // Datapath pipeline
    logic              rd_vld;
    logic [LEN_W-1:0]  wr_idx;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [63:0]       wr_data_q;
    logic [63:0]       lane_sum;

    assign rd_idx_nxt = rd_idx + LEN_W'(1);
    assign last_rd    = (rd_idx == (len_q - LEN_W'(1)));

    // Control FSM: accepts commands, issues reads, waits for the pipeline to drain, then pulses done
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            y_base_q <= '0;
            rd_idx   <= '0;
            rd_en_q  <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q    <= bus.len;
                        a_base_q <= bus.a_base;
                        b_base_q <= bus.b_base;
                        y_base_q <= bus.y_base;
                        busy_q   <= 1'b1;
                        if (bus.len != '0) begin
                            state    <= RUN;
                            rd_idx   <= '0;
                            rd_en_q  <= 1'b1;
                            a_addr_q <= bus.a_base;
                            b_addr_q <= bus.b_base;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_rd) begin
                        state    <= DRAIN;
                        rd_en_q  <= 1'b0;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                    end else begin
                        rd_idx   <= rd_idx_nxt;
                        a_addr_q <= a_base_q + ADDR_W'(rd_idx_nxt);
                        b_addr_q <= b_base_q + ADDR_W'(rd_idx_nxt);
                    end
                end
                DRAIN: begin
                    if (!rd_vld) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Lane-wise add of the returning read data; each 16-bit lane wraps on its own
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < 4; l++) begin
            lane_sum[16*l +: 16] = bus.a_rd_data[16*l +: 16] + bus.b_rd_data[16*l +: 16];
        end
    end

    // Write stage: registers the sum and the Y address one cycle after read data returns
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld    <= 1'b0;
            wr_idx    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_vld  <= rd_en_q;
            wr_en_q <= rd_vld;
            if (rd_vld) begin
                wr_addr_q <= y_base_q + ADDR_W'(wr_idx);
                wr_data_q <= lane_sum;
                wr_idx    <= wr_idx + LEN_W'(1);
            end else begin
                wr_addr_q <= '0;
                wr_data_q <= '0;
                wr_idx    <= '0;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.a_rd_en   = rd_en_q;
    assign bus.b_rd_en   = rd_en_q;
    assign bus.a_rd_addr = a_addr_q;
    assign bus.b_rd_addr = b_addr_q;
    assign bus.y_wr_en   = wr_en_q;
    assign bus.y_wr_addr = wr_addr_q;
    assign bus.y_wr_data = wr_data_q;

endmodule

// File: tb/tb_vec_add_ctrl.sv
// Scoreboard bench for vec_add_ctrl.
// Each command pushes its expected reads, writes and done cycle into queues.
// A negedge monitor pops those queues and compares them with the DUT activity.
module tb_vec_add_ctrl;

    localparam int AW = 8;
    localparam int LW = 8;

    typedef struct {
        int             cyc;
        logic [AW-1:0]  a;
        logic [AW-1:0]  b;
    } rd_t;

    typedef struct {
        int             cyc;
        logic [AW-1:0]  addr;
        logic [63:0]    data;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc;

    int   n_checks;
    int   n_fail;

    logic [63:0] mem_a [256];
    logic [63:0] mem_b [256];
    logic [63:0] exp_y [256];

    rd_t  rd_q [$];
    wr_t  wr_q [$];
    int   done_q [$];
    rd_t  keep_rd [$];
    wr_t  keep_wr [$];
    rd_t  mon_r;
    wr_t  mon_w;
    int   mon_d;

    int   busy_lo;
    int   busy_hi;
    int   t0;
    int   t_ign;

    vec_add_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

    vec_add_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter; at a negedge it names the current cycle
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read SRAM models: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (bus.a_rd_en) bus.a_rd_data <= mem_a[bus.a_rd_addr];
        if (bus.b_rd_en) bus.b_rd_data <= mem_b[bus.b_rd_addr];
    end

    // Compares one value, bumps the counters and reports a mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Independent lane-wise add used to fill expected Y values
    function automatic logic [63:0] laneAdd(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) r[16*l +: 16] = a[16*l +: 16] + b[16*l +: 16];
        return r;
    endfunction

    // Fills exp_y from the memory images at the given bases, with 8-bit wrap
    task automatic fillModel(input int n, input logic [AW-1:0] ab, input logic [AW-1:0] bb);
        logic [AW-1:0] ia;
        logic [AW-1:0] ib;
        for (int i = 0; i < n; i++) begin
            ia = ab + AW'(i);
            ib = bb + AW'(i);
            exp_y[i] = laneAdd(mem_a[ia], mem_b[ib]);
        end
    endtask

    // Drives start for one cycle.
    // When track is set, it also queues the expected reads, writes, done cycle and busy window.
    task automatic applyStimulus(input int n, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                                 input logic [AW-1:0] yb, input bit track, output int ts);
        rd_t tr;
        wr_t tw;
        @(negedge clk);
        ts         = cyc;
        bus.start  = 1'b1;
        bus.len    = LW'(n);
        bus.a_base = ab;
        bus.b_base = bb;
        bus.y_base = yb;
        if (track) begin
            for (int i = 0; i < n; i++) begin
                tr.cyc  = ts + 1 + i;
                tr.a    = ab + AW'(i);
                tr.b    = bb + AW'(i);
                rd_q.push_back(tr);
                tw.cyc  = ts + 3 + i;
                tw.addr = yb + AW'(i);
                tw.data = exp_y[i];
                wr_q.push_back(tw);
            end
            busy_lo = ts + 1;
            busy_hi = (n == 0) ? ts + 1 : ts + n + 3;
            done_q.push_back(busy_hi);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits, with a cycle budget, until every queued event has been seen and busy has ended
    task automatic waitDone(input int limit);
        int n;
        n = 0;
        while ((rd_q.size() > 0 || wr_q.size() > 0 || done_q.size() > 0 || cyc <= busy_hi) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_in_budget", 64'(n < limit), 64'd1);
        @(negedge clk);
    endtask

    // Waits for the negedge of cycle c
    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: checks every cycle's reads, writes, done and busy against the scoreboard
    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("b_rd_en_eq_a_rd_en", 64'(bus.b_rd_en), 64'(bus.a_rd_en));
            if (bus.a_rd_en) begin
                checkOutput("rd_expected", 64'(rd_q.size() > 0), 64'd1);
                if (rd_q.size() > 0) begin
                    mon_r = rd_q.pop_front();
                    checkOutput("rd_cycle", 64'(cyc), 64'(mon_r.cyc));
                    checkOutput("a_rd_addr", 64'(bus.a_rd_addr), 64'(mon_r.a));
                    checkOutput("b_rd_addr", 64'(bus.b_rd_addr), 64'(mon_r.b));
                end
            end else begin
                checkOutput("a_rd_addr_idle", 64'(bus.a_rd_addr), 64'd0);
                checkOutput("b_rd_addr_idle", 64'(bus.b_rd_addr), 64'd0);
            end
            if (bus.y_wr_en) begin
                checkOutput("wr_expected", 64'(wr_q.size() > 0), 64'd1);
                if (wr_q.size() > 0) begin
                    mon_w = wr_q.pop_front();
                    checkOutput("wr_cycle", 64'(cyc), 64'(mon_w.cyc));
                    checkOutput("y_wr_addr", 64'(bus.y_wr_addr), 64'(mon_w.addr));
                    checkOutput("y_wr_data", bus.y_wr_data, mon_w.data);
                end
            end else begin
                checkOutput("y_wr_addr_idle", 64'(bus.y_wr_addr), 64'd0);
                checkOutput("y_wr_data_idle", bus.y_wr_data, 64'd0);
            end
            if (bus.done) begin
                checkOutput("done_expected", 64'(done_q.size() > 0), 64'd1);
                if (done_q.size() > 0) begin
                    mon_d = done_q.pop_front();
                    checkOutput("done_cycle", 64'(cyc), 64'(mon_d));
                end
            end
            checkOutput("busy", 64'(bus.busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    // Directed sequence
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        busy_lo    = 1;
        busy_hi    = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.len    = '0;
        bus.a_base = '0;
        bus.b_base = '0;
        bus.y_base = '0;

        for (int k = 0; k < 256; k++) begin
            mem_a[k] = {16'(k), 16'(k * 7 + 3), 16'(255 - k), 16'(k * k)};
            mem_b[k] = {16'(k * 13), 16'(65535 - k), 16'(k + 100), 16'(k * k * 5)};
        end
        mem_a[16] = 64'h0000_0000_0000_0000;
        mem_a[17] = 64'h0001_0002_0003_0004;
        mem_a[18] = 64'h0002_0004_0006_0008;
        mem_a[19] = 64'h0003_0006_0009_000C;
        for (int k = 32; k < 36; k++) mem_b[k] = 64'h0010_0010_0010_0010;
        mem_a[8'h40] = 64'hFFFF_8000_0001_7FFF;
        mem_b[8'h50] = 64'h0001_8000_FFFF_0001;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_rd_en", 64'(bus.a_rd_en), 64'd0);
        checkOutput("reset_wr_en", 64'(bus.y_wr_en), 64'd0);
        checkOutput("reset_wr_data", bus.y_wr_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic len=4");
        exp_y[0] = 64'h0010_0010_0010_0010;
        exp_y[1] = 64'h0011_0012_0013_0014;
        exp_y[2] = 64'h0012_0014_0016_0018;
        exp_y[3] = 64'h0013_0016_0019_001C;
        applyStimulus(4, 8'h10, 8'h20, 8'h30, 1'b1, t0);
        waitDone(60);

        $display("[TB] lane overflow len=1");
        exp_y[0] = 64'h0000_0000_0000_8000;
        applyStimulus(1, 8'h40, 8'h50, 8'h60, 1'b1, t0);
        waitDone(60);

        $display("[TB] zero length");
        applyStimulus(0, 8'h70, 8'h70, 8'h70, 1'b1, t0);
        waitDone(60);

        $display("[TB] address wrap");
        fillModel(4, 8'hFE, 8'hFF);
        applyStimulus(4, 8'hFE, 8'hFF, 8'hFD, 1'b1, t0);
        waitDone(60);

        $display("[TB] ignored starts");
        fillModel(8, 8'h80, 8'h90);
        applyStimulus(8, 8'h80, 8'h90, 8'hA0, 1'b1, t0);
        applyStimulus(3, 8'h00, 8'h00, 8'h00, 1'b0, t_ign);
        waitUntil(t0 + 10);
        applyStimulus(2, 8'hC0, 8'hC0, 8'hC0, 1'b0, t_ign);
        waitDone(80);

        $display("[TB] reset mid-run");
        fillModel(8, 8'h20, 8'h30);
        applyStimulus(8, 8'h20, 8'h30, 8'h40, 1'b1, t0);
        @(negedge clk);
        @(negedge clk);
        keep_rd = {};
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i].cyc < t0 + 4) keep_rd.push_back(rd_q[i]);
        rd_q = keep_rd;
        keep_wr = {};
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i].cyc < t0 + 4) keep_wr.push_back(wr_q[i]);
        wr_q = keep_wr;
        done_q.delete();
        busy_hi = t0 + 3;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_outputs",
                    64'({bus.a_rd_en, bus.b_rd_en, bus.y_wr_en, bus.busy, bus.done}), 64'd0);
        waitUntil(t0 + 5);
        fillModel(2, 8'h05, 8'h06);
        applyStimulus(2, 8'h05, 8'h06, 8'h07, 1'b1, t_ign);
        checkOutput("restart_cycle", 64'(t_ign), 64'(t0 + 6));
        waitDone(60);

        checkOutput("leftover_expectations", 64'(rd_q.size() + wr_q.size() + done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
